// File: rtl/ct_spsram_init_wrap.sv
// Single-port SRAM wrapper that fills every entry with INIT_VAL after reset or on request.
// Latency: a read accepted in cycle n shows on Q in cycle n+1, or n+2 with SPSRAM_OUT_REG_EN.
// Backpressure: none. Accesses made while INIT_BUSY=1 are dropped and flagged on ACC_ERR.
//
// Optional macro SPSRAM_OUT_REG_EN adds an output register after the array.
//
// Ports (all active-low macro-style controls):
//   CLK, RST       clock, synchronous active-high reset
//   A, CEN, GWEN   address, chip enable, global write enable (1 = read)
//   WEN, D         per-group write enables (bit i covers D[i*GW +: GW]), write data
//   INIT_REQ       single-cycle request to refill the array (honoured only when idle)
//   Q              held read data
//   INIT_BUSY      fill in progress
//   INIT_DONE      one-cycle pulse after the last fill write
//   ACC_ERR        one-cycle pulse after an access that arrived while busy

// Behavioural single-port array. Read data is registered (latency 1) and only
// changes on a read. Byte enables are active-high.
module tc_sram #(
   parameter int unsigned NumWords  = 512,
   parameter int unsigned DataWidth = 7,
   parameter int unsigned ByteWidth = 1
) (
   input  logic                                   clk_i,
   input  logic                                   req_i,
   input  logic                                   we_i,
   input  logic [$clog2(NumWords)-1:0]            addr_i,
   input  logic [DataWidth-1:0]                   wdata_i,
   input  logic [DataWidth/ByteWidth-1:0]         be_i,
   output logic [DataWidth-1:0]                   rdata_o
);
   localparam int unsigned BeWidth = DataWidth / ByteWidth;

   logic [DataWidth-1:0] mem_q [NumWords];
   logic [DataWidth-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (req_i) begin
         if (we_i) begin
            for (int unsigned i = 0; i < BeWidth; i++) begin
               if (be_i[i]) begin
                  mem_q[addr_i][i*ByteWidth +: ByteWidth] <= wdata_i[i*ByteWidth +: ByteWidth];
               end
            end
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;
endmodule

module ct_spsram_init_wrap #(
   parameter int unsigned          ADDR_WIDTH = 9,
   parameter int unsigned          DATA_WIDTH = 7,
   parameter int unsigned          WE_WIDTH   = 7,
   parameter logic [DATA_WIDTH-1:0] INIT_VAL  = '0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic                  CEN,
   input  logic                  GWEN,
   input  logic [WE_WIDTH-1:0]   WEN,
   input  logic [DATA_WIDTH-1:0] D,
   input  logic                  INIT_REQ,
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  INIT_BUSY,
   output logic                  INIT_DONE,
   output logic                  ACC_ERR
);
   localparam int unsigned         GW      = DATA_WIDTH / WE_WIDTH;
   localparam logic [ADDR_WIDTH:0] CntLast = {1'b0, {ADDR_WIDTH{1'b1}}};
   localparam logic [ADDR_WIDTH:0] CntOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic {
      ST_INIT,
      ST_IDLE
   } state_e;

   state_e                state_q;
   logic [ADDR_WIDTH:0]   cnt_q;      // one spare bit so the last address never wraps
   logic                  busy_q;
   logic                  done_q;
   logic                  err_q;
   logic                  rvalid_q;   // array read data is valid this cycle
   logic [DATA_WIDTH-1:0] q_q;
   logic [DATA_WIDTH-1:0] q_d;

   logic                  init_wr;
   logic                  acc_vld;
   logic                  sram_req;
   logic                  sram_we;
   logic [ADDR_WIDTH-1:0] sram_addr;
   logic [DATA_WIDTH-1:0] sram_wdata;
   logic [WE_WIDTH-1:0]   sram_be;
   logic [DATA_WIDTH-1:0] sram_rdata;

   // Fill writes and functional accesses are mutually exclusive by state;
   // nothing reaches the array while RST is high.
   assign init_wr = (state_q == ST_INIT) && !RST;
   assign acc_vld = (state_q == ST_IDLE) && !CEN && !RST;

   always_comb begin
      sram_req   = init_wr || acc_vld;
      sram_we    = init_wr || !GWEN;
      sram_addr  = A;
      sram_wdata = D;
      sram_be    = ~WEN;
      if (init_wr) begin
         sram_addr  = cnt_q[ADDR_WIDTH-1:0];
         sram_wdata = INIT_VAL;
         sram_be    = '1;
      end
   end

   tc_sram #(
      .NumWords  (2**ADDR_WIDTH),
      .DataWidth (DATA_WIDTH),
      .ByteWidth (GW)
   ) u_sram (
      .clk_i   (CLK),
      .req_i   (sram_req),
      .we_i    (sram_we),
      .addr_i  (sram_addr),
      .wdata_i (sram_wdata),
      .be_i    (sram_be),
      .rdata_o (sram_rdata)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_INIT;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         err_q    <= (state_q == ST_INIT) && !CEN;
         rvalid_q <= acc_vld && GWEN;
         case (state_q)
            ST_INIT: begin
               cnt_q <= cnt_q + CntOne;
               if (cnt_q == CntLast) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               // A coincident access has already been issued this cycle.
               if (INIT_REQ) begin
                  state_q <= ST_INIT;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
         endcase
      end
   end

   // Held read data: only a completed read replaces it, so fill writes,
   // functional writes and idle cycles leave Q untouched.
   always_comb begin
      q_d = q_q;
      if (rvalid_q) begin
         q_d = sram_rdata;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

`ifdef SPSRAM_OUT_REG_EN
   assign Q = q_q;
`else
   assign Q = q_d;
`endif

   assign INIT_BUSY = busy_q;
   assign INIT_DONE = done_q;
   assign ACC_ERR   = err_q;
endmodule

// File: doc/ct_spsram_init_wrap.md
Name: ct_spsram_init_wrap

Overview:
- Parametrised single-port SRAM wrapper: configurable address, data and write-enable-group widths; active-low CEN/GWEN/WEN macro-style interface.
- Adds a hardware initialisation sequencer that fills every entry with INIT_VAL after reset or on request.
- Adds a held read-data register and an access-violation flag.
- Serves as the common base for LSU/IFU tag and dirty arrays that currently need software or per-array invalidation logic.

Parameters:
- ADDR_WIDTH, 9, address bits; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 7, data bits per entry.
- WE_WIDTH, 7, write-enable groups; DATA_WIDTH must be a multiple of WE_WIDTH; group width GW = DATA_WIDTH/WE_WIDTH.
- INIT_VAL, 0, DATA_WIDTH-bit fill value written during initialisation.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- A  in  ADDR_WIDTH  access address.
- CEN  in  1  chip enable, active-low.
- GWEN  in  1  global write enable, active-low; 1 = read.
- WEN  in  WE_WIDTH  group write enables, active-low; bit i covers D[i*GW +: GW].
- D  in  DATA_WIDTH  write data.
- INIT_REQ  in  1  single-cycle re-initialisation request.
- Q  out  DATA_WIDTH  read data.
- INIT_BUSY  out  1  initialisation in progress; functional accesses are not accepted.
- INIT_DONE  out  1  one-cycle pulse when initialisation completes.
- ACC_ERR  out  1  one-cycle pulse; a functional access arrived while INIT_BUSY=1.

Behaviour:
- Reset values while RST=1: state=INIT, init counter=0, INIT_BUSY=1, INIT_DONE=0, ACC_ERR=0, Q=0. No array write occurs during reset cycles.
- FSM states:
  - INIT: each cycle, write INIT_VAL to address = counter with all groups enabled, then counter+1.
    - When counter == 2**ADDR_WIDTH-1, that write occurs, then next state is IDLE and INIT_DONE=1 for exactly the following cycle.
    - Fill takes 2**ADDR_WIDTH cycles after RST deasserts.
    - INIT_REQ is ignored in INIT.
  - IDLE: INIT_BUSY=0.
    - INIT_REQ=1 → next state INIT, counter cleared to 0.
    - If INIT_REQ coincides with a functional access, the access is performed this cycle and INIT begins next cycle.
- Functional access is accepted only in IDLE with CEN=0.
  - Write (GWEN=0): groups with WEN[i]=0 are updated from D; other groups are unchanged.
  - GWEN=0 with WEN all 1 is a legal no-op write.
  - Read (GWEN=1): Q presents mem[A] on the cycle after acceptance (latency 1).
  - Q holds its last read value through idle cycles, writes and initialisation. Q is not updated by init writes.
  - Read-after-write to the same address in consecutive cycles returns the newly written data. There is no same-cycle bypass.
- Access while INIT_BUSY=1 (CEN=0): the access is dropped (no array write, Q unchanged) and ACC_ERR=1 on the next cycle.
- RST asserted mid-initialisation or mid-access: state returns to INIT with counter 0 on that edge; the pending read result is discarded (Q=0).
- The counter is ADDR_WIDTH+1 bits internally; no wrap past the last address.
- Storage: tc_sram instance, NumWords=2**ADDR_WIDTH, Latency 1.
  - Init port mux selects counter/INIT_VAL/all-enables while INIT_BUSY=1.
  - Q capture uses a registered read-valid flag.

Optional Feature:
- Macro SPSRAM_OUT_REG_EN.
- Defined: an extra output register follows the SRAM.
  - Read latency is 2 cycles; Q updates only two cycles after an accepted read.
  - The register resets to 0.
  - INIT_DONE still pulses the cycle after the last init write.
  - A read accepted in the final IDLE cycle before INIT_REQ still returns its data.
- Not defined: latency 1 as above; no extra register.

Test Plan:
- ADDR_WIDTH=4, DATA_WIDTH=8, WE_WIDTH=2, INIT_VAL=8'hA5; release RST → INIT_BUSY=1 for 16 cycles, INIT_DONE pulses once; reads of addresses 0..15 all return 8'hA5 one cycle after each request.
- After init: write A=3, D=8'h3C, WEN=2'b00; then write A=3, D=8'hFF, WEN=2'b10 → read A=3 returns 8'h3F.
- CEN=0 read at A=5 while INIT_BUSY=1 (cycle 4 of init) → ACC_ERR=1 next cycle, Q unchanged at 0, mem[5]=8'hA5 after init.
- INIT_REQ in IDLE after writing 8'h11 to A=7 → 16 busy cycles, INIT_DONE pulse; read A=7 returns 8'hA5; INIT_REQ pulsed mid-init does not extend busy time.
- RST asserted at init cycle 9 for 1 cycle → init restarts from address 0, busy for a full 16 more cycles, exactly one INIT_DONE.
- With SPSRAM_OUT_REG_EN defined: read A=2 holding 8'h5A → Q=8'h5A exactly 2 cycles after request, and Q holds that value through 3 subsequent idle cycles.
